// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder.
//   WORD_SIZE   : width of one memory word and of every data/address port
//   mem_state_t : responder FSM states (clearing the array / serving requests)
package mem_responder_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_responder_sat_counter.sv
// Saturating up-counter.
//   Clk   : clock
//   Reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU's instruction-fetch port (port 1, read
// only) and data port (port 2, bidirectional data2). Clears the whole array
// after reset, accepts program preload, counts accesses and keeps sticky
// error flags.
//   Clk, Reset                     : clock, synchronous active-high reset
//   readM1, address1, data1        : port-1 read request, address, read data
//   readM2, writeM2, address2      : port-2 read/write requests and address
//   data2                          : port-2 data, driven here only on reads
//   load_en, load_addr, load_data  : preload write request
//   load_ack                       : preload accepted on the previous edge
//   busy                           : array clear in progress
//   rd1_cnt, rd2_cnt, wr2_cnt      : saturating access counters
//   err_conflict, err_range        : sticky error flags
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  input  logic                 load_en,
  input  logic [WORD_SIZE-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 load_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     rd1_cnt,
  output logic [CNT_W-1:0]     rd2_cnt,
  output logic [CNT_W-1:0]     wr2_cnt,
  output logic                 err_conflict,
  output logic                 err_range
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

  mem_state_t           state, state_nxt;
  logic [ADDR_W-1:0]    clr_ptr;
  logic                 ready;
  logic                 in1, in2, inl;
  logic                 wr2_ok, ld_ok, range_hit;
  logic                 wen;
  logic [ADDR_W-1:0]    waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rd2_val;

  assign ready = (state == MEM_READY);
  assign in1   = (address1[WORD_SIZE-1:ADDR_W] == '0);
  assign in2   = (address2[WORD_SIZE-1:ADDR_W] == '0);
  assign inl   = (load_addr[WORD_SIZE-1:ADDR_W] == '0);

  // A legal port-2 write always beats a preload, whatever the preload address.
  assign wr2_ok = ready && writeM2 && in2;
  assign ld_ok  = ready && load_en && inl && !wr2_ok;

  assign range_hit = ready && ((readM1 && !in1) || (readM2 && !in2) ||
                               (writeM2 && !in2) || (load_en && !inl));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= MEM_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_CLEAR: if (&clr_ptr) state_nxt = MEM_READY;
      MEM_READY: state_nxt = MEM_READY;
      default:   state_nxt = MEM_CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      if (state == MEM_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      busy <= (state_nxt == MEM_CLEAR);
    end
  end

  // Single write port: clear sweep, port-2 write or preload. Reset itself
  // never touches the array.
  always_comb begin
    wen   = 1'b0;
    waddr = clr_ptr;
    wdata = '0;
    if (!Reset) begin
      if (state == MEM_CLEAR) begin
        wen = 1'b1;
      end else if (wr2_ok) begin
        wen   = 1'b1;
        waddr = address2[ADDR_W-1:0];
        wdata = data2;
      end else if (ld_ok) begin
        wen   = 1'b1;
        waddr = load_addr[ADDR_W-1:0];
        wdata = load_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_ack     <= 1'b0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      load_ack <= ld_ok;
      if (ready && readM2 && writeM2) err_conflict <= 1'b1;
      if (range_hit)                  err_range    <= 1'b1;
    end
  end

  // Zero-latency reads; the array is read before any same-edge write lands.
  assign data1   = (readM1 && ready && in1) ? mem[address1[ADDR_W-1:0]] : '0;
  assign rd2_val = (ready && in2) ? mem[address2[ADDR_W-1:0]] : '0;
  assign data2   = (readM2 && !writeM2) ? rd2_val : {WORD_SIZE{1'bz}};

  sat_counter #(.W(CNT_W)) u_rd1_cnt (
    .Clk(Clk), .Reset(Reset), .inc(ready && readM1), .count(rd1_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rd2_cnt (
    .Clk(Clk), .Reset(Reset), .inc(ready && readM2 && !writeM2), .count(rd2_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wr2_cnt (
    .Clk(Clk), .Reset(Reset), .inc(ready && writeM2), .count(wr2_cnt)
  );

endmodule
